alu_arbiter: RTL

Two-requester round-robin arbiter that shares the CPU's single 32-bit ALU (add/sub/and/or/shift datapath) between the pipeline execute stage (requester 0) and the multiply/divide unit (requester 1). It latches the winner's opcode and operands, drives them onto the shared ALU, captures the ALU result and overflow one cycle later, and returns them with a one-cycle done pulse. It sits between both requesters and the ALU instance in the processor top level.

---
 rtl/alu_arbiter_if.sv | 47 ++++
 rtl/alu_arbiter.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: requester, shared-ALU and status signals of alu_arbiter.
// slave is the arbiter side, master the requester/ALU side.
interface alu_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 5,
    parameter int SH_W   = 5
);
    logic              req0;
    logic              req1;
    logic [OP_W-1:0]   op0;
    logic [OP_W-1:0]   op1;
    logic [SH_W-1:0]   shamt0;
    logic [SH_W-1:0]   shamt1;
    logic [DATA_W-1:0] a0;
    logic [DATA_W-1:0] b0;
    logic [DATA_W-1:0] a1;
    logic [DATA_W-1:0] b1;
    logic [OP_W-1:0]   alu_opcode;
    logic [SH_W-1:0]   alu_shamt;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_result;
    logic              alu_ovf;
    logic              done0;
    logic              done1;
    logic [DATA_W-1:0] result;
    logic              ovf;
    logic              busy;
    logic [15:0]       gnt_cnt0;
    logic [15:0]       gnt_cnt1;

    modport slave (
        input  req0, req1, op0, op1, shamt0, shamt1,
        input  a0, b0, a1, b1, alu_result, alu_ovf,
        output alu_opcode, alu_shamt, alu_a, alu_b,
        output done0, done1, result, ovf, busy,
        output gnt_cnt0, gnt_cnt1
    );

    modport master (
        output req0, req1, op0, op1, shamt0, shamt1,
        output a0, b0, a1, b1, alu_result, alu_ovf,
        input  alu_opcode, alu_shamt, alu_a, alu_b,
        input  done0, done1, result, ovf, busy,
        input  gnt_cnt0, gnt_cnt1
    );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin share of one ALU between two requesters.
// Define ALU_ARB_COUNT_EN to build the saturating per-requester grant counters.
module alu_arbiter #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 5,
    parameter int SH_W   = 5
) (
    input logic           clock,
    input logic           reset,
    alu_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t            state, state_n;
    logic              prio, prio_n;
    logic              win, win_n;
    logic              pick;
    logic [OP_W-1:0]   opcode_q, opcode_n;
    logic [SH_W-1:0]   shamt_q, shamt_n;
    logic [DATA_W-1:0] a_q, a_n;
    logic [DATA_W-1:0] b_q, b_n;
    logic [DATA_W-1:0] result_q, result_n;
    logic              ovf_q, ovf_n;
    logic              done0_q, done0_n;
    logic              done1_q, done1_n;
    logic              busy_q, busy_n;

    // lone request wins outright; contention goes to the pointer
    assign pick = (bus.req0 && bus.req1) ? prio : bus.req1;

    // next state and next value of every registered output
    always_comb begin
        state_n  = state;
        prio_n   = prio;
        win_n    = win;
        opcode_n = opcode_q;
        shamt_n  = shamt_q;
        a_n      = a_q;
        b_n      = b_q;
        result_n = result_q;
        ovf_n    = ovf_q;
        done0_n  = 1'b0;
        done1_n  = 1'b0;
        busy_n   = busy_q;
        unique case (state)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    win_n    = pick;
                    prio_n   = ~pick;
                    opcode_n = pick ? bus.op1 : bus.op0;
                    shamt_n  = pick ? bus.shamt1 : bus.shamt0;
                    a_n      = pick ? bus.a1 : bus.a0;
                    b_n      = pick ? bus.b1 : bus.b0;
                    busy_n   = 1'b1;
                    state_n  = ISSUE;
                end
            end
            ISSUE: begin
                result_n = bus.alu_result;
                ovf_n    = bus.alu_ovf;
                done0_n  = ~win;
                done1_n  = win;
                busy_n   = 1'b1;
                state_n  = RESP;
            end
            RESP: begin
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            default: begin
                busy_n  = 1'b0;
                state_n = IDLE;
            end
        endcase
    end

    // state and output registers; reset abandons any in-flight op
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            prio     <= 1'b0;
            win      <= 1'b0;
            opcode_q <= '0;
            shamt_q  <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state    <= state_n;
            prio     <= prio_n;
            win      <= win_n;
            opcode_q <= opcode_n;
            shamt_q  <= shamt_n;
            a_q      <= a_n;
            b_q      <= b_n;
            result_q <= result_n;
            ovf_q    <= ovf_n;
            done0_q  <= done0_n;
            done1_q  <= done1_n;
            busy_q   <= busy_n;
        end
    end

    assign bus.alu_opcode = opcode_q;
    assign bus.alu_shamt  = shamt_q;
    assign bus.alu_a      = a_q;
    assign bus.alu_b      = b_q;
    assign bus.result     = result_q;
    assign bus.ovf        = ovf_q;
    assign bus.done0      = done0_q;
    assign bus.done1      = done1_q;
    assign bus.busy       = busy_q;

`ifdef ALU_ARB_COUNT_EN
    logic        grant;
    logic [15:0] cnt0, cnt1;

    assign grant = (state == IDLE) && (bus.req0 || bus.req1);

    // count grants on the IDLE->ISSUE edge, holding at all-ones
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else if (grant) begin
            if (!pick && cnt0 != 16'hFFFF) cnt0 <= cnt0 + 16'd1;
            if (pick && cnt1 != 16'hFFFF)  cnt1 <= cnt1 + 16'd1;
        end
    end

    assign bus.gnt_cnt0 = cnt0;
    assign bus.gnt_cnt1 = cnt1;
`else
    assign bus.gnt_cnt0 = '0;
    assign bus.gnt_cnt1 = '0;
`endif
endmodule
